data_mem_unit: RTL and testbench

- Word-organised data memory that sits directly downstream of the multicycle processor core.
- Consumes dAddress, dWriteData, MemRead and MemWrite from the core during its MEM state. Produces dReadData, registered, so that it is valid in the core's WB state.
- Adds misalignment and out-of-range detection with sticky error flags, plus saturating access counters for bench and debug visibility.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_unit.sv | 115 +++++++++++
 tb/tb_data_mem_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory unit.
//   - default data-segment base address and depth
//   - opcode constants shared with the core's control FSM
//   - dmem_decode(): computes in_range and word offset for a byte address
package dmem_pkg;

  localparam logic [31:0] DMEM_DATA_BASE   = 32'h1001_0000;
  localparam int unsigned DMEM_DEPTH_WORDS = 1024;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef struct packed {
    logic        in_range;
    logic [31:0] index;   // full word offset; caller keeps the low log2(depth) bits
  } dmem_dec_t;

  function automatic dmem_dec_t dmem_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned depth);
    dmem_dec_t   d;
    logic [31:0] off;
    logic [31:0] lim;
    off        = addr - base;
    lim        = depth << 2;
    d.in_range = (addr >= base) && (off < lim);
    d.index    = off >> 2;
    return d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 32-bit synchronous RAM with a registered, enabled read and no reset.
// Ports:
//   clk    - clock
//   we     - write enable, writes wdata to mem[wa]
//   re     - read enable, loads rdata from mem[ra]
//   wa/ra  - word indices
//   wdata  - write data
//   rdata  - registered read data (holds when re=0)
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] wa,
  input  logic [IDX_W-1:0] ra,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata;
    if (re) rdata   <= mem[ra];
  end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: word-organised data memory downstream of the multicycle core.
// Decodes dAddress against the data segment, performs accepted writes/reads,
// and raises sticky misalignment / out-of-range / protocol error flags.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   MemRead, MemWrite   - level-sampled strobes from the core
//   dAddress            - byte address
//   dWriteData          - store data
//   dReadData           - registered load data (1-cycle latency)
//   mis_err, range_err  - sticky error flags
//   proto_err           - sticky flag: read and write strobes together
//   rd_cnt, wr_cnt      - saturating accepted-access counters
// Optional feature macro: DMEM_STATS_EN builds the counters and proto_err
// detection; without it rd_cnt, wr_cnt and proto_err are tied to 0.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DMEM_DATA_BASE,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      dAddress,
  input  logic [31:0]      dWriteData,
  output logic [31:0]      dReadData,
  output logic             mis_err,
  output logic             range_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmem_dec_t   dec;
  logic        aligned, valid, access;
  logic        do_write, do_read, rd_inv;
  logic [31:0] arr_rdata;
  logic        zero_q, mis_q, range_q;
  logic        unused_idx_hi;

  always_comb begin
    dec      = dmem_decode(dAddress, DATA_BASE, DEPTH_WORDS);
    aligned  = (dAddress[1:0] == 2'b00);
    valid    = dec.in_range && aligned;
    access   = MemRead || MemWrite;
    do_write = MemWrite && valid && !rst;
    do_read  = MemRead && !MemWrite && valid && !rst;
    rd_inv   = MemRead && !MemWrite && !valid;
  end

  assign unused_idx_hi = ^dec.index[31:IDX_W];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (do_write),
    .re    (do_read),
    .wa    (dec.index[IDX_W-1:0]),
    .ra    (dec.index[IDX_W-1:0]),
    .wdata (dWriteData),
    .rdata (arr_rdata)
  );

  // The RAM output register has no reset, so zero_q masks it after reset and
  // after an invalid read; both registers hold together on non-read cycles,
  // which keeps dReadData stable without a second data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b1;
      mis_q   <= 1'b0;
      range_q <= 1'b0;
    end else begin
      if (rd_inv)       zero_q <= 1'b1;
      else if (do_read) zero_q <= 1'b0;
      if (access && !aligned)      mis_q   <= 1'b1;
      if (access && !dec.in_range) range_q <= 1'b1;
    end
  end

  assign dReadData = zero_q ? '0 : arr_rdata;
  assign mis_err   = mis_q;
  assign range_err = range_q;

`ifdef DMEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
  logic             proto_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      if (do_read  && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (do_write && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (MemRead && MemWrite)          proto_q  <= 1'b1;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = proto_q;
`else
  assign rd_cnt    = '0;
  assign wr_cnt    = '0;
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: randomized self-checking bench for data_mem_unit with a
// word-array reference model of the data segment. CNT_W=4 for saturation.
module tb_data_mem_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned DEPTH = 1024;
`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite;
  logic [31:0] dAddress, dWriteData, dReadData;
  logic        mis_err, range_err, proto_err;
  logic [3:0]  rd_cnt, wr_cnt;

  data_mem_unit #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .dReadData  (dReadData),
    .mis_err    (mis_err),
    .range_err  (range_err),
    .proto_err  (proto_err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mem_m [DEPTH];
  logic [31:0] e_rd;
  logic        e_mis, e_rng, e_proto;
  logic [3:0]  e_rdc, e_wrc;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Drive one cycle of stimulus, advance past the edge and update the model.
  task automatic step(input bit r, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
    bit          inr, al;
    int unsigned idx;
    rst = r; MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d;
    @(posedge clk);
    #1;
    if (r) begin
      e_rd = 0; e_mis = 0; e_rng = 0; e_proto = 0; e_rdc = 0; e_wrc = 0;
    end else begin
      inr = (a >= BASE) && ((a - BASE) < DEPTH * 4);
      al  = (a % 4) == 0;
      idx = (a - BASE) / 4;
      if (rd || wr) begin
        if (!al)  e_mis = 1;
        if (!inr) e_rng = 1;
      end
      if (rd && wr && STATS) e_proto = 1;
      if (wr) begin
        if (inr && al) begin
          mem_m[idx] = d;
          if (STATS && e_wrc != 4'hF) e_wrc = e_wrc + 1;
        end
      end else if (rd) begin
        if (inr && al) begin
          e_rd = mem_m[idx];
          if (STATS && e_rdc != 4'hF) e_rdc = e_rdc + 1;
        end else begin
          e_rd = 0;
        end
      end
    end
    rst = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic test_init;
    step(1, 0, 0, 0, 0);
    for (int unsigned i = 0; i < DEPTH; i++)
      step(0, 0, 1, BASE + 4 * i, $urandom);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    logic [31:0] old;
    old = mem_m[2];
    step(0, 1, 0, BASE + 8, 0);  // make dReadData non-zero before reset
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, BASE + 8, 32'hCAFE_F00D);
      n_cmp++;
      if ({dReadData, mis_err, range_err, proto_err, rd_cnt, wr_cnt} !== 43'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rd=%h mis=%b rng=%b pro=%b rc=%0d wc=%0d required all 0",
                 dReadData, mis_err, range_err, proto_err, rd_cnt, wr_cnt);
      end
    end
    step(0, 1, 0, BASE + 8, 0);
    n_cmp++;
    if (dReadData !== old) begin
      n_fail++;
      $display("FAIL reset_no_write: got %h required %h", dReadData, old);
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_store_load;
    step(0, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF);
    step(0, 1, 0, 32'h1001_0004, 0);
    n_cmp++;
    if (dReadData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_load_data: got %h required deadbeef", dReadData);
    end
    n_cmp++;
    if ({rd_cnt, wr_cnt} !== {4'(STATS), 4'(STATS)}) begin
      n_fail++;
      $display("FAIL store_load_counts: got rc=%0d wc=%0d required %0d each", rd_cnt, wr_cnt, STATS);
    end
  endtask

  task automatic test_misaligned;
    step(0, 1, 0, 32'h1001_0006, 0);
    n_cmp++;
    if ({dReadData, mis_err, range_err, rd_cnt} !== {32'd0, 1'b1, 1'b0, e_rdc}) begin
      n_fail++;
      $display("FAIL misaligned_read: got rd=%h mis=%b rng=%b rc=%0d required 0/1/0/%0d",
               dReadData, mis_err, range_err, rd_cnt, e_rdc);
    end
    step(0, 1, 0, 32'h1001_0004, 0);
    n_cmp++;
    if ({dReadData, mis_err} !== {32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL misaligned_recover: got rd=%h mis=%b required deadbeef/1", dReadData, mis_err);
    end
  endtask

  task automatic test_range;
    logic [31:0] d, w0;
    d  = $urandom;
    w0 = mem_m[0];
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, BASE + 4092, d);
    step(0, 1, 0, BASE + 4092, 0);
    n_cmp++;
    if ({dReadData, range_err} !== {d, 1'b0}) begin
      n_fail++;
      $display("FAIL range_top_word: got rd=%h rng=%b required %h/0", dReadData, range_err, d);
    end
    step(0, 0, 1, BASE + 4096, 32'h1234_5678);
    n_cmp++;
    if (range_err !== 1'b1 || wr_cnt !== e_wrc) begin
      n_fail++;
      $display("FAIL range_write_past_end: got rng=%b wc=%0d required 1/%0d", range_err, wr_cnt, e_wrc);
    end
    step(0, 1, 0, BASE, 0);
    n_cmp++;
    if (dReadData !== w0) begin
      n_fail++;
      $display("FAIL range_no_alias: got %h required %h", dReadData, w0);
    end
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, BASE, 0);
    step(0, 1, 0, 32'h1000_FFFC, 0);
    n_cmp++;
    if ({dReadData, range_err, mis_err} !== {32'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL range_below_base: got rd=%h rng=%b mis=%b required 0/1/0", dReadData, range_err, mis_err);
    end
  endtask

  task automatic test_simultaneous;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, BASE + 12, 0);
    step(0, 1, 1, 32'h1001_0010, 32'd5);
    n_cmp++;
    if ({dReadData, proto_err, wr_cnt, rd_cnt} !== {mem_m[3], STATS, 4'(STATS), 4'(STATS)}) begin
      n_fail++;
      $display("FAIL simul_rw: got rd=%h pro=%b wc=%0d rc=%0d required %h/%0d/%0d/%0d",
               dReadData, proto_err, wr_cnt, rd_cnt, mem_m[3], STATS, STATS, STATS);
    end
    step(0, 1, 0, 32'h1001_0010, 0);
    n_cmp++;
    if ({dReadData, proto_err} !== {32'd5, STATS}) begin
      n_fail++;
      $display("FAIL simul_written: got rd=%h pro=%b required 5/%0d", dReadData, proto_err, STATS);
    end
  endtask

  task automatic test_saturation;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, BASE + 4 * $urandom_range(0, DEPTH - 1), 0);
      n_cmp++;
      if ({rd_cnt, dReadData} !== {e_rdc, e_rd}) begin
        n_fail++;
        $display("FAIL saturation_read%0d: got rc=%0d rd=%h required %0d/%h", i, rd_cnt, dReadData, e_rdc, e_rd);
      end
    end
    n_cmp++;
    if (rd_cnt !== (STATS ? 4'hF : 4'h0)) begin
      n_fail++;
      $display("FAIL saturation_final: got %0d required %0d", rd_cnt, STATS ? 15 : 0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    for (int i = 0; i < 8; i++) begin
      a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      d = $urandom;
      step(0, 0, 1, a, d);
      step(0, 1, 0, a, 0);
      n_cmp++;
      if (dReadData !== d) begin
        n_fail++;
        $display("FAIL back_to_back%0d: addr %h got %h required %h", i, a, dReadData, d);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    bit          r, rd, wr;
    int unsigned k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      if (k == 0) a = a + $urandom_range(1, 3);
      else if (k == 1) a = ($urandom_range(0, 1) != 0) ? BASE - 4 * $urandom_range(1, 16)
                                                        : BASE + DEPTH * 4 + 4 * $urandom_range(0, 16);
      else if (k == 2) a = $urandom;
      r  = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) == 0);
      step(r, rd, wr, a, $urandom);
      n_cmp++;
      if ({dReadData, mis_err, range_err, proto_err, rd_cnt, wr_cnt} !==
          {e_rd, e_mis, e_rng, e_proto, e_rdc, e_wrc}) begin
        n_fail++;
        $display("FAIL random%0d: addr %h r%b rd%b wr%b got rd=%h mis=%b rng=%b pro=%b rc=%0d wc=%0d required rd=%h mis=%b rng=%b pro=%b rc=%0d wc=%0d",
                 i, a, r, rd, wr, dReadData, mis_err, range_err, proto_err, rd_cnt, wr_cnt,
                 e_rd, e_mis, e_rng, e_proto, e_rdc, e_wrc);
      end
    end
  endtask

  initial begin
    rst = 1; MemRead = 0; MemWrite = 0; dAddress = 0; dWriteData = 0;
    test_init();
    test_reset();
    test_store_load();
    test_misaligned();
    test_range();
    test_simultaneous();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
